// File: rtl/light_chaser_if.sv
// Bus for the light_chaser LED pattern generator.
//   enable  : advance the chaser when 1, hold when 0
//   dir     : rotation direction, 0 = left, 1 = right (only with LIGHTCHASER_DIR_EN)
//   led_out : registered one-hot LED pattern, WIDTH bits
// Modports: master drives enable/dir and observes led_out; slave is the chaser itself.
// Optional feature macro: LIGHTCHASER_DIR_EN (adds dir).
interface light_chaser_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] led_out;
`ifdef LIGHTCHASER_DIR_EN
  logic             dir;

  modport master (output enable, output dir, input led_out);
  modport slave  (input enable, input dir, output led_out);
`else
  modport master (output enable, input led_out);
  modport slave  (input enable, output led_out);
`endif
endinterface

// File: rtl/light_chaser.sv
// Rotating one-hot LED chaser. The pattern rotates by one bit every TICKS_PER_STEP
// enabled clock cycles; while enable is low the pattern and the tick counter freeze, so
// motion resumes exactly where it paused.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (pattern -> bit0, tick counter -> 0)
//   bus   : light_chaser_if.slave (enable in, optional dir in, led_out out)
// Parameters: WIDTH (>= 2) LEDs, TICKS_PER_STEP (>= 1) enabled cycles per step.
// Optional feature macro: LIGHTCHASER_DIR_EN adds bus.dir (1 = rotate right).
module light_chaser #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TICKS_PER_STEP = 4
) (
  input logic           clk,
  input logic           rst_n,
  light_chaser_if.slave bus
);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 2) begin : g_bad_width
    $error("light_chaser: WIDTH must be >= 2");
  end
  if (TICKS_PER_STEP < 1) begin : g_bad_ticks
    $error("light_chaser: TICKS_PER_STEP must be >= 1");
  end

  localparam int unsigned    CNT_W   = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  // With TICKS_PER_STEP == 1 this is 0, so every enabled edge steps and the counter
  // never leaves 0 -- no special case needed.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_STEP - 1);

  logic [WIDTH-1:0] led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step;
  logic             go_right;

`ifdef LIGHTCHASER_DIR_EN
  assign go_right = bus.dir;
`else
  assign go_right = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (bus.enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end
    end
  end

  always_comb begin
    led_d = led_q;
    if (step) begin
      if (go_right) begin
        led_d = {led_q[0], led_q[WIDTH-1:1]};
      end else begin
        led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= WIDTH'(1);
      cnt_q <= '0;
    end else begin
      led_q <= led_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.led_out = led_q;

endmodule

// File: tb/tb_light_chaser.sv
// Directed bench for light_chaser (WIDTH=8, TICKS_PER_STEP=3) plus a second instance
// built with TICKS_PER_STEP=1. Expected patterns come from a small reference model and
// are queued when stimulus is applied, then popped and compared after the edge.
module tb_light_chaser;

  localparam int unsigned W = 8;
  localparam int unsigned T = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  light_chaser_if #(.WIDTH(W)) bus  ();
  light_chaser_if #(.WIDTH(W)) bus1 ();

  light_chaser #(.WIDTH(W), .TICKS_PER_STEP(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  light_chaser #(.WIDTH(W), .TICKS_PER_STEP(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state for the T=3 instance.
  logic [W-1:0] m_led;
  int unsigned  m_cnt;
  logic         m_dir;
  logic [W-1:0] m1_led;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] sb1_q[$];

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
    return (x << 1) | (x >> (W - 1));
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x);
    return (x >> 1) | (x << (W - 1));
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_led  = W'(1);
    m_cnt  = 0;
    m1_led = W'(1);
  endtask

  // Apply one clock of stimulus to the T=3 instance and compare after the edge.
  task automatic drive_edge(input logic en, input string tag);
    logic [W-1:0] exp;
    bus.enable = en;
    if (en) begin
      if (m_cnt == T - 1) begin
        m_cnt = 0;
        m_led = m_dir ? rotr(m_led) : rotl(m_led);
      end else begin
        m_cnt++;
      end
    end
    sb_q.push_back(m_led);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, bus.led_out, 'x);
    end else begin
      exp = sb_q.pop_front();
      check(tag, bus.led_out, exp);
    end
  endtask

  task automatic drive_edge1(input string tag);
    logic [W-1:0] exp;
    bus1.enable = 1'b1;
    m1_led = rotl(m1_led);
    sb1_q.push_back(m1_led);
    @(posedge clk);
    #1;
    exp = sb1_q.pop_front();
    check(tag, bus1.led_out, exp);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus1.enable = 1'b0;
    m_dir       = 1'b0;
`ifdef LIGHTCHASER_DIR_EN
    bus.dir     = 1'b0;
    bus1.dir    = 1'b0;
`endif
    model_reset();

    // Reset for 4 cycles.
    repeat (4) @(posedge clk);
    #1;
    check("reset", bus.led_out, 8'h01);
    check("reset_t1", bus1.led_out, 8'h01);
    rst_n = 1'b1;

    // Disabled: no movement.
    for (int i = 0; i < 10; i++) drive_edge(1'b0, "idle");
    check("idle_end", bus.led_out, 8'h01);

    // 30 enabled edges -> 10 steps -> 8'h04.
    for (int i = 0; i < 30; i++) drive_edge(1'b1, "run30");
    check("after30", bus.led_out, 8'h04);

    // Mid-step pause with counter at 2.
    drive_edge(1'b1, "pause_pre");
    drive_edge(1'b1, "pause_pre");
    for (int i = 0; i < 7; i++) drive_edge(1'b0, "paused");
    check("paused_hold", bus.led_out, 8'h04);
    drive_edge(1'b1, "resume");
    check("resume_step", bus.led_out, 8'h08);
    for (int i = 0; i < 3; i++) drive_edge(1'b1, "resume_next");
    check("resume_next_step", bus.led_out, 8'h10);

    // Walk to 8'h80, then wrap to 8'h01, then a full 24-edge lap.
    for (int i = 0; i < 9; i++) drive_edge(1'b1, "to80");
    check("at80", bus.led_out, 8'h80);
    for (int i = 0; i < 3; i++) drive_edge(1'b1, "wrap");
    check("wrap01", bus.led_out, 8'h01);
    for (int i = 0; i < 24; i++) drive_edge(1'b1, "lap");
    check("lap01", bus.led_out, 8'h01);

    // Async reset mid-step, counter = 1, pattern 8'h02.
    for (int i = 0; i < 4; i++) drive_edge(1'b1, "pre_rst");
    check("pre_rst_state", bus.led_out, 8'h02);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst", bus.led_out, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    drive_edge(1'b1, "post_rst1");
    drive_edge(1'b1, "post_rst2");
    check("post_rst_hold", bus.led_out, 8'h01);
    drive_edge(1'b1, "post_rst3");
    check("post_rst_step", bus.led_out, 8'h02);

    // TICKS_PER_STEP=1 instance rotates on every edge.
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) drive_edge1("t1_run");
    check("t1_after10", bus1.led_out, 8'h04);
    bus1.enable = 1'b0;

`ifdef LIGHTCHASER_DIR_EN
    // Right rotation from reset: 8'h01 -> 8'h80 after 3 edges.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    m_dir   = 1'b1;
    bus.dir = 1'b1;
    for (int i = 0; i < 3; i++) drive_edge(1'b1, "dir_right");
    check("dir_right80", bus.led_out, 8'h80);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
